// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcode constants, format codes and the
// decoded-instruction record that the decode FIFO stores.
package riscv_pkg;

  localparam int IMM_MAX = 64;

  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_BTYPE   = 7'b1100011;
  localparam logic [6:0] OP_LOADS   = 7'b0000011;
  localparam logic [6:0] OP_STORES  = 7'b0100011;
  localparam logic [6:0] OP_ARITH_I = 7'b0010011;
  localparam logic [6:0] OP_ARITH_R = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // imm is always held at the widest legal XLEN; narrower stages truncate.
  typedef struct packed {
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [IMM_MAX-1:0] imm;
    fmt_e               fmt;
    logic               illegal;
  } dec_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational format classification, legality check and sign-extended
// immediate generation for one RV32I instruction word.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0]        instr,
  output logic [IMM_MAX-1:0] imm,
  output fmt_e               fmt,
  output logic               illegal
);

  logic [6:0] op;
  logic [2:0] f3;

  assign op = instr[6:0];
  assign f3 = instr[14:12];

  always_comb begin
    fmt     = FMT_R;
    illegal = 1'b0;
    imm     = '0;
    case (op)
      OP_LUI, OP_AUIPC:              fmt = FMT_U;
      OP_JAL:                        fmt = FMT_J;
      OP_JALR: begin
        fmt     = FMT_I;
        illegal = (f3 != 3'b000);
      end
      OP_LOADS, OP_ARITH_I:          fmt = FMT_I;
      OP_BTYPE:                      fmt = FMT_B;
      OP_STORES:                     fmt = FMT_S;
      OP_ARITH_R:                    fmt = FMT_R;
      default:                       illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) illegal = 1'b1;
    // Illegal words degrade to R so the immediate below collapses to zero.
    if (illegal) fmt = FMT_R;
    case (fmt)
      FMT_I: imm = {{52{instr[31]}}, instr[31:20]};
      FMT_S: imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm = {{32{instr[31]}}, instr[31:12], 12'b0};
      FMT_J: imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: decodes on acceptance into a 2-entry FIFO whose head drives
// the outputs. Valid/ready on both sides, flush and async reset.
module instr_decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            FLUSH,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [31:0]     INSTR,
  input  logic [PC_W-1:0] PC_IN,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [6:0]      OPCODE,
  output logic [2:0]      FUNCT3,
  output logic [6:0]      FUNCT7,
  output logic [4:0]      RS1,
  output logic [4:0]      RS2_SHAMT,
  output logic [4:0]      RD,
  output logic [XLEN-1:0] IMM,
  output logic [2:0]      FMT,
  output logic            ILLEGAL,
  output logic [PC_W-1:0] PC_OUT
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_e;

  occ_e              state, state_nxt;
  logic              in_ready_q;
  logic              push, pop;
  logic              wr_ptr, rd_ptr;
  dec_t              dec_in, head;
  dec_t              mem    [2];
  logic [PC_W-1:0]   pc_mem [2];
  logic [IMM_MAX-1:0] ig_imm;
  fmt_e              ig_fmt;
  logic              ig_ill;

  imm_gen u_imm_gen (
    .instr   (INSTR),
    .imm     (ig_imm),
    .fmt     (ig_fmt),
    .illegal (ig_ill)
  );

  always_comb begin
    dec_in.opcode  = INSTR[6:0];
    dec_in.funct3  = INSTR[14:12];
    dec_in.funct7  = INSTR[31:25];
    dec_in.rs1     = INSTR[19:15];
    dec_in.rs2     = INSTR[24:20];
    dec_in.rd      = INSTR[11:7];
    dec_in.imm     = ig_imm;
    dec_in.fmt     = ig_fmt;
    dec_in.illegal = ig_ill;
  end

  // Flush overrides both sides of the handshake.
  assign push = IN_VALID & in_ready_q & ~FLUSH;
  assign pop  = OUT_VALID & OUT_READY & ~FLUSH;

  always_comb begin
    state_nxt = state;
    if (FLUSH) state_nxt = EMPTY;
    else begin
      case (state)
        EMPTY:   if (push) state_nxt = ONE;
        ONE:     if (push && !pop) state_nxt = FULL;
                 else if (pop && !push) state_nxt = EMPTY;
        FULL:    if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= EMPTY;
      in_ready_q <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != FULL);
      wr_ptr     <= FLUSH ? 1'b0 : (wr_ptr ^ push);
      rd_ptr     <= FLUSH ? 1'b0 : (rd_ptr ^ pop);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 2; i++) begin
        mem[i]    <= '0;
        pc_mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr]    <= dec_in;
      pc_mem[wr_ptr] <= PC_IN;
    end
  end

  assign head      = mem[rd_ptr];
  assign IN_READY  = in_ready_q;
  assign OUT_VALID = (state != EMPTY);
  assign OPCODE    = head.opcode;
  assign FUNCT3    = head.funct3;
  assign FUNCT7    = head.funct7;
  assign RS1       = head.rs1;
  assign RS2_SHAMT = head.rs2;
  assign RD        = head.rd;
  assign IMM       = head.imm[XLEN-1:0];
  assign FMT       = head.fmt;
  assign ILLEGAL   = head.illegal;
  assign PC_OUT    = pc_mem[rd_ptr];

  if (XLEN < IMM_MAX) begin : g_trunc
    logic unused_imm_hi;
    assign unused_imm_hi = ^head.imm[IMM_MAX-1:XLEN];
  end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: XLEN=32 and XLEN=64 instances in lockstep,
// table-driven vectors through a scoreboard plus backpressure/flush/reset cases.
module tb_instr_decode_stage;
  import riscv_pkg::*;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic        CLK = 1'b0, RST_N = 1'b0, FLUSH = 1'b0, IN_VALID = 1'b0, OUT_READY = 1'b0;
  logic [31:0] INSTR = '0, PC_IN = '0;

  logic        iready32, ovalid32, ill32, iready64, ovalid64, ill64;
  logic [6:0]  op32, f7_32, op64, f7_64;
  logic [2:0]  f3_32, fmt32, f3_64, fmt64;
  logic [4:0]  rs1_32, rs2_32, rd_32, rs1_64, rs2_64, rd_64;
  logic [31:0] imm32, pco32, pco64;
  logic [63:0] imm64;

  int   n_cmp = 0, n_bad = 0;
  exp_t sb[$];
  exp_t tbl[13];
  exp_t mon_e;

  always #5 CLK = ~CLK;

  instr_decode_stage #(.XLEN(32), .PC_W(32)) dut32 (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(iready32),
    .INSTR(INSTR), .PC_IN(PC_IN), .OUT_VALID(ovalid32), .OUT_READY(OUT_READY),
    .OPCODE(op32), .FUNCT3(f3_32), .FUNCT7(f7_32), .RS1(rs1_32), .RS2_SHAMT(rs2_32),
    .RD(rd_32), .IMM(imm32), .FMT(fmt32), .ILLEGAL(ill32), .PC_OUT(pco32)
  );

  instr_decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(iready64),
    .INSTR(INSTR), .PC_IN(PC_IN), .OUT_VALID(ovalid64), .OUT_READY(OUT_READY),
    .OPCODE(op64), .FUNCT3(f3_64), .FUNCT7(f7_64), .RS1(rs1_64), .RS2_SHAMT(rs2_64),
    .RD(rd_64), .IMM(imm64), .FMT(fmt64), .ILLEGAL(ill64), .PC_OUT(pco64)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] i, input logic [63:0] imm,
                              input logic [2:0] f, input logic ill);
    exp_t e;
    e.instr = i; e.pc = '0; e.imm = imm; e.fmt = f; e.ill = ill;
    return e;
  endfunction

  task automatic cmp_out(input exp_t e);
    chk("opcode",  64'(op32),   64'(e.instr[6:0]));
    chk("funct3",  64'(f3_32),  64'(e.instr[14:12]));
    chk("funct7",  64'(f7_32),  64'(e.instr[31:25]));
    chk("rs1",     64'(rs1_32), 64'(e.instr[19:15]));
    chk("rs2",     64'(rs2_32), 64'(e.instr[24:20]));
    chk("rd",      64'(rd_32),  64'(e.instr[11:7]));
    chk("pc_out",  64'(pco32),  64'(e.pc));
    chk("imm32",   64'(imm32),  64'(e.imm[31:0]));
    chk("fmt32",   64'(fmt32),  64'(e.fmt));
    chk("ill32",   64'(ill32),  64'(e.ill));
    chk("valid64", 64'(ovalid64), 64'd1);
    chk("rd64",    64'(rd_64),  64'(e.instr[11:7]));
    chk("imm64",   imm64,       e.imm);
    chk("fmt64",   64'(fmt64),  64'(e.fmt));
    chk("ill64",   64'(ill64),  64'(e.ill));
  endtask

  // A transfer is committed at the next rising edge; compare against the head.
  always @(negedge CLK) begin
    if (RST_N && !FLUSH && OUT_READY && ovalid32) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL spurious_out: got opcode %h with nothing expected (t=%0t)", op32, $time);
      end else begin
        mon_e = sb.pop_front();
        cmp_out(mon_e);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input exp_t v);
    bit done = 1'b0;
    IN_VALID = 1'b1; INSTR = v.instr; PC_IN = v.pc;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge CLK);
      if (iready32) begin sb.push_back(v); done = 1'b1; end
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got no IN_READY expected acceptance of %h", v.instr);
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 50 && sb.size() != 0; c++) begin
      @(posedge CLK); #1;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(32'hFFFFF0B7, 64'hFFFFFFFF_FFFFF000, FMT_U, 1'b0); // LUI x1
    tbl[1]  = mk(32'hFFF00093, 64'hFFFFFFFF_FFFFFFFF, FMT_I, 1'b0); // ADDI x1,x0,-1
    tbl[2]  = mk(32'hFE000EE3, 64'hFFFFFFFF_FFFFFFFC, FMT_B, 1'b0); // BEQ -4
    tbl[3]  = mk(32'h00000000, 64'h0,                 FMT_R, 1'b1);
    tbl[4]  = mk(32'h123090E7, 64'h0,                 FMT_R, 1'b1); // JALR funct3=1
    tbl[5]  = mk(32'hFE20AC23, 64'hFFFFFFFF_FFFFFFF8, FMT_S, 1'b0); // SW -8
    tbl[6]  = mk(32'h001000EF, 64'h00000000_00000800, FMT_J, 1'b0); // JAL +2048
    tbl[7]  = mk(32'hFFFFF0EF, 64'hFFFFFFFF_FFFFFFFE, FMT_J, 1'b0); // JAL -2
    tbl[8]  = mk(32'h12345017, 64'h00000000_12345000, FMT_U, 1'b0); // AUIPC
    tbl[9]  = mk(32'h0040A103, 64'h00000000_00000004, FMT_I, 1'b0); // LW +4
    tbl[10] = mk(32'h002081B3, 64'h0,                 FMT_R, 1'b0); // ADD
    tbl[11] = mk(32'h00000090, 64'h0,                 FMT_R, 1'b1); // bits[1:0]=00
    tbl[12] = mk(32'hFFC08067, 64'hFFFFFFFF_FFFFFFFC, FMT_I, 1'b0); // JALR -4
    for (int i = 0; i < 13; i++) tbl[i].pc = 32'h1000 + 32'(4 * i);

    // Reset state
    #2;
    chk("rst_iready", 64'(iready32), 64'd0);
    chk("rst_ovalid", 64'(ovalid32), 64'd0);
    chk("rst_ovalid64", 64'(ovalid64), 64'd0);
    chk("rst_imm64", imm64, 64'd0);
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("iready_after_rst", 64'(iready32), 64'd1);
    chk("ovalid_after_rst", 64'(ovalid32), 64'd0);

    // One-cycle latency on the LUI, then the whole table back-to-back
    OUT_READY = 1'b1;
    send(tbl[0]);
    chk("lat_ovalid", 64'(ovalid32), 64'd1);
    chk("lat_imm32", 64'(imm32), 64'hFFFFF000);
    chk("lat_imm64", imm64, 64'hFFFFFFFF_FFFFF000);
    @(posedge CLK); #1;
    for (int i = 0; i < 13; i++) send(tbl[i]);
    drain();

    // Backpressure: two fill the FIFO, third waits, head frozen
    OUT_READY = 1'b0;
    send(tbl[0]); send(tbl[1]);
    IN_VALID = 1'b1; INSTR = tbl[2].instr; PC_IN = tbl[2].pc;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("full_iready", 64'(iready32), 64'd0);
      chk("frozen_valid", 64'(ovalid32), 64'd1);
      chk("frozen_imm", 64'(imm32), 64'hFFFFF000);
      chk("frozen_pc", 64'(pco32), 64'(tbl[0].pc));
      @(posedge CLK); #1;
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    chk("pop_iready_same", 64'(iready32), 64'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("pop_iready_next", 64'(iready32), 64'd1);
    if (iready32) sb.push_back(tbl[2]);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    drain();

    // Flush while FULL with a pending input
    OUT_READY = 1'b0;
    send(tbl[5]); send(tbl[6]);
    FLUSH = 1'b1; IN_VALID = 1'b1; INSTR = tbl[7].instr; PC_IN = tbl[7].pc; OUT_READY = 1'b1;
    @(negedge CLK); sb.delete();
    @(posedge CLK); #1;
    FLUSH = 1'b0; IN_VALID = 1'b0;
    @(negedge CLK);
    chk("flush_ovalid", 64'(ovalid32), 64'd0);
    chk("flush_iready", 64'(iready32), 64'd1);
    repeat (3) @(posedge CLK);
    #1;

    // Flush from ONE with a real concurrent push, then check pointer rewind
    OUT_READY = 1'b0;
    send(tbl[8]);
    FLUSH = 1'b1; IN_VALID = 1'b1; INSTR = tbl[9].instr; PC_IN = tbl[9].pc;
    @(negedge CLK);
    chk("flush1_iready", 64'(iready32), 64'd1);
    sb.delete();
    @(posedge CLK); #1;
    FLUSH = 1'b0; IN_VALID = 1'b0;
    @(negedge CLK);
    chk("flush1_ovalid", 64'(ovalid32), 64'd0);
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    send(tbl[10]); send(tbl[12]);
    drain();

    // Reset mid-stream with two entries buffered
    OUT_READY = 1'b0;
    send(tbl[3]); send(tbl[4]);
    #2 RST_N = 1'b0;
    #1;
    chk("mrst_ovalid", 64'(ovalid32), 64'd0);
    chk("mrst_iready", 64'(iready32), 64'd0);
    chk("mrst_opcode", 64'(op32), 64'd0);
    chk("mrst_pc", 64'(pco32), 64'd0);
    sb.delete();
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("mrst_iready_rel", 64'(iready32), 64'd1);
    chk("mrst_ovalid_rel", 64'(ovalid32), 64'd0);
    OUT_READY = 1'b1;
    send(tbl[1]);
    drain();
    repeat (2) @(posedge CLK);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
